// File: rtl/multicycle_control.sv
//-----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle MIPS control FSM.
// Each instruction is sequenced over 3-5 cycles: fetch, decode, execute,
// memory and writeback. Memory accesses use a ready handshake. A wait counter
// bounds how long a memory state can stall, and a one-cycle retire strobe
// marks the end of every instruction.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an unknown opcode goes DECODE -> TRAP -> HALT and sets the
//               sticky illegal_op output.
//   undefined : an unknown opcode retires as a NOP from DECODE.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode, funct     IR[31:26] and IR[5:0]
//   zero              ALU zero flag, used by beq/bne
//   mem_ready         memory access completes this cycle
//   pc_write, ir_write, iord, regdst, mem_to_reg, alu_src_a, alu_src_b,
//   alu_op, pc_src, reg_write, jal
//                     datapath controls
//   mem_read_n, mem_write_n, mem_enable_n
//                     active-low memory strobes
//   instr_done        one-cycle retire pulse
//   mem_err           sticky memory-timeout flag
//   illegal_op        sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
//   state             current state code, for debug
//-----------------------------------------------------------------------------
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                iord,
  output logic                regdst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                jal,
  output logic                mem_read_n,
  output logic                mem_write_n,
  output logic                mem_enable_n,
  output logic                instr_done,
  output logic                mem_err,
`ifdef ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic [3:0]          state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_JR        = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;
  localparam logic [3:0] S_IDLE      = 4'd14;
  localparam logic [3:0] S_HALT      = 4'd15;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] FN_JR    = OPCODE_W'(6'b001000);

  // Last allowed waiting cycle index; counter value while on the WAIT_MAX-th cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = {WAIT_W{1'b1}};

  logic [3:0]        state_r;
  logic [3:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_err_r;
  logic              in_wait_s;
  logic              timeout_s;

  // True for every opcode the decoder recognises.
  function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_LW, OP_SW:               known = 1'b1;
      default:                             known = 1'b0;
    endcase
    return known;
  endfunction

  assign in_wait_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
  // Stall on the WAIT_MAX-th cycle in a memory state is fatal; ready on it is success.
  assign timeout_s = in_wait_s && !mem_ready && (wait_cnt_r == WAIT_LAST);

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   state_nxt_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_nxt_s = S_DECODE;
        else if (timeout_s) state_nxt_s = S_HALT;
        else                state_nxt_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_nxt_s = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct == FN_JR) state_nxt_s = S_JR;
            else                state_nxt_s = S_R_EXEC;
          end
          OP_BEQ, OP_BNE: state_nxt_s = S_BRANCH;
          OP_ADDI:        state_nxt_s = S_ADDI_EXEC;
          OP_J, OP_JAL:   state_nxt_s = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:        state_nxt_s = S_TRAP;
`else
          default:        state_nxt_s = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) state_nxt_s = S_MEM_RD;
        else                 state_nxt_s = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready)      state_nxt_s = S_MEM_WB;
        else if (timeout_s) state_nxt_s = S_HALT;
        else                state_nxt_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready)      state_nxt_s = S_FETCH;
        else if (timeout_s) state_nxt_s = S_HALT;
        else                state_nxt_s = S_MEM_WR;
      end
      S_R_EXEC:    state_nxt_s = S_R_WB;
      S_ADDI_EXEC: state_nxt_s = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP, S_JR:
                   state_nxt_s = S_FETCH;
      S_TRAP:      state_nxt_s = S_HALT;
      S_HALT:      state_nxt_s = S_HALT;
      default:     state_nxt_s = S_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Wait counter: cleared on any state change, counts stalled cycles, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                wait_cnt_r <= {WAIT_W{1'b0}};
    else if (state_nxt_s != state_r)                           wait_cnt_r <= {WAIT_W{1'b0}};
    else if (in_wait_s && !mem_ready && wait_cnt_r != WAIT_SAT) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    else                                                       wait_cnt_r <= wait_cnt_r;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         mem_err_r <= 1'b0;
    else if (timeout_s) mem_err_r <= 1'b1;
    else                mem_err_r <= mem_err_r;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_op_r;

  // Sticky illegal-opcode flag, set on entry to TRAP so it is visible there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    illegal_op_r <= 1'b0;
    else if (state_nxt_s == S_TRAP) illegal_op_r <= 1'b1;
    else                           illegal_op_r <= illegal_op_r;
  end

  assign illegal_op = illegal_op_r;
`endif

  assign state   = state_r;
  assign mem_err = mem_err_r;

  // Control outputs: Moore per state, plus the Mealy terms on mem_ready/zero/opcode.
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = ALU_OP_W'(2'b11);
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    jal          = 1'b0;
    mem_read_n   = 1'b1;
    mem_write_n  = 1'b1;
    mem_enable_n = 1'b1;
    instr_done   = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_enable_n = 1'b0;
        mem_read_n   = 1'b0;
        alu_src_b    = 2'b01;
        alu_op       = ALU_OP_W'(2'b00);
        ir_write     = mem_ready;
        pc_write     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_OP_W'(2'b00);
`ifdef ILLEGAL_TRAP_EN
        instr_done = 1'b0;
`else
        instr_done = !is_known_op(opcode);
`endif
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_OP_W'(2'b00);
      end
      S_MEM_RD: begin
        iord         = 1'b1;
        mem_enable_n = 1'b0;
        mem_read_n   = 1'b0;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord         = 1'b1;
        mem_enable_n = 1'b0;
        mem_write_n  = 1'b0;
        instr_done   = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_W'(2'b10);
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_OP_W'(2'b01);
        pc_src     = 2'b01;
        instr_done = 1'b1;
        if (opcode == OP_BEQ) pc_write = zero;
        else                  pc_write = !zero;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          jal       = 1'b1;
        end else begin
          reg_write = 1'b0;
          jal       = 1'b0;
        end
      end
      S_JR: begin
        pc_src     = 2'b11;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
//-----------------------------------------------------------------------------
// tb_multicycle_control
// Stimulus walks each instruction through the state sequence that the
// instruction class implies. For every cycle it pushes the expected state,
// control word, mem_err and illegal_op values into a queue. The monitor pops
// one entry per cycle at the falling edge and compares it with the DUT.
//-----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3;
  localparam int S_MEM_WB = 4, S_MEM_WR = 5, S_R_EXEC = 6, S_R_WB = 7;
  localparam int S_BRANCH = 8, S_ADDI_EXEC = 9, S_ADDI_WB = 10, S_JUMP = 11;
  localparam int S_JR = 12, S_TRAP = 13, S_IDLE = 14, S_HALT = 15;
  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, regdst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       reg_write, jal, mem_read_n, mem_write_n, mem_enable_n;
  logic       instr_done, mem_err;
  logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .regdst(regdst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_write(reg_write),
    .jal(jal), .mem_read_n(mem_read_n), .mem_write_n(mem_write_n),
    .mem_enable_n(mem_enable_n), .instr_done(instr_done), .mem_err(mem_err),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state(state)
  );

  typedef struct {
    int         st;
    logic [17:0] ctrl;
    logic       err;
    logic       ill;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc_no = 0;
  logic [5:0] cur_op = 6'd0;
  logic [5:0] cur_fn = 6'd0;
  logic       cur_z = 1'b0;
  logic       err_exp = 1'b0;
  logic       ill_exp = 1'b0;
  logic [17:0] act_ctrl;

  assign act_ctrl = {pc_write, ir_write, iord, regdst, mem_to_reg, alu_src_a,
                     alu_src_b, alu_op, pc_src, reg_write, jal,
                     mem_read_n, mem_write_n, mem_enable_n, instr_done};

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43};
  endfunction

  // Control word table taken from the per-state output list.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic z, input logic rdy);
    logic pcw, irw, io, rd, m2r, asa, rw, jl, mrn, mwn, men, done;
    logic [1:0] asb, aop, psrc;
    pcw = 1'b0; irw = 1'b0; io = 1'b0; rd = 1'b0; m2r = 1'b0; asa = 1'b0;
    rw = 1'b0; jl = 1'b0; mrn = 1'b1; mwn = 1'b1; men = 1'b1; done = 1'b0;
    asb = 2'b00; aop = 2'b11; psrc = 2'b00;
    case (st)
      S_FETCH:     begin men = 1'b0; mrn = 1'b0; asb = 2'b01; aop = 2'b00; irw = rdy; pcw = rdy; end
      S_DECODE: begin
        asb = 2'b11; aop = 2'b00;
`ifdef ILLEGAL_TRAP_EN
        done = 1'b0;
`else
        done = !legal(op);
`endif
      end
      S_MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; aop = 2'b00; end
      S_MEM_RD:    begin io = 1'b1; men = 1'b0; mrn = 1'b0; end
      S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      S_MEM_WR:    begin io = 1'b1; men = 1'b0; mwn = 1'b0; done = rdy; end
      S_R_EXEC:    begin asa = 1'b1; asb = 2'b00; aop = 2'b10; end
      S_R_WB:      begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
      S_BRANCH:    begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; done = 1'b1;
                         pcw = (op == 6'd4) ? z : !z; end
      S_ADDI_EXEC: begin asa = 1'b1; asb = 2'b10; aop = 2'b00; end
      S_ADDI_WB:   begin rw = 1'b1; done = 1'b1; end
      S_JUMP:      begin psrc = 2'b10; pcw = 1'b1; done = 1'b1;
                         rw = (op == 6'd3); jl = (op == 6'd3); end
      S_JR:        begin psrc = 2'b11; pcw = 1'b1; done = 1'b1; end
      default:     begin done = 1'b0; end
    endcase
    return {pcw, irw, io, rd, m2r, asa, asb, aop, psrc, rw, jl, mrn, mwn, men, done};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(0, 7) == 0) return WAIT_MAX - 1;
    return int'($urandom_range(0, 4));
  endfunction

  task automatic push(input int st, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    opcode    = cur_op;
    funct     = cur_fn;
    zero      = cur_z;
    e.st   = st;
    e.ctrl = exp_ctrl(st, cur_op, cur_z, rdy);
    e.err  = err_exp;
    e.ill  = ill_exp;
    q.push_back(e);
  endtask

  task automatic cyc(input int st, input logic rdy);
    @(posedge clk);
    #1;
    push(st, rdy);
  endtask

  task automatic wait_mem(input int st, input int w);
    for (int i = 0; i < w; i++) cyc(st, 1'b0);
    cyc(st, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    err_exp = 1'b0;
    ill_exp = 1'b0;
    push(S_IDLE, rnd());
    cyc(S_IDLE, rnd());
    cyc(S_IDLE, rnd());
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    cur_op = op;
    cur_fn = fn;
    cur_z  = z;
    wait_mem(S_FETCH, fw);
    cyc(S_DECODE, rnd());
    if (op == 6'd35 || op == 6'd43) begin
      cyc(S_MEM_ADDR, rnd());
      if (op == 6'd35) begin
        wait_mem(S_MEM_RD, mw);
        cyc(S_MEM_WB, rnd());
      end else begin
        wait_mem(S_MEM_WR, mw);
      end
    end else if (op == 6'd0) begin
      if (fn == 6'd8) cyc(S_JR, rnd());
      else begin
        cyc(S_R_EXEC, rnd());
        cyc(S_R_WB, rnd());
      end
    end else if (op == 6'd4 || op == 6'd5) begin
      cyc(S_BRANCH, rnd());
    end else if (op == 6'd8) begin
      cyc(S_ADDI_EXEC, rnd());
      cyc(S_ADDI_WB, rnd());
    end else if (op == 6'd2 || op == 6'd3) begin
      cyc(S_JUMP, rnd());
    end else begin
`ifdef ILLEGAL_TRAP_EN
      ill_exp = 1'b1;
      cyc(S_TRAP, rnd());
      cyc(S_HALT, rnd());
      cyc(S_HALT, rnd());
`endif
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc_no, got, want);
    end
  endtask

  // Monitor: one expected entry per cycle, compared away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        cyc_no++;
        check("state", 32'(state), 32'(mon_e.st));
        check("ctrl", 32'(act_ctrl), 32'(mon_e.ctrl));
        check("mem_err", 32'(mem_err), 32'(mon_e.err));
`ifdef ILLEGAL_TRAP_EN
        check("illegal_op", 32'(illegal_op), 32'(mon_e.ill));
`endif
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         k;

    do_reset();
    // Directed sequences from the test plan, then waits at the boundary.
    run_instr(6'd35, 6'd0, 1'b0, 0, 0);
    run_instr(6'd4, 6'd0, 1'b1, 0, 0);
    run_instr(6'd5, 6'd0, 1'b1, 0, 0);
    run_instr(6'd0, 6'd8, 1'b0, 0, 0);
    run_instr(6'd0, 6'd32, 1'b0, 0, 0);
    run_instr(6'd43, 6'd0, 1'b0, 0, 0);
    run_instr(6'd8, 6'd0, 1'b0, 0, 0);
    run_instr(6'd2, 6'd0, 1'b0, 0, 0);
    run_instr(6'd3, 6'd0, 1'b0, 0, 0);
    run_instr(6'd35, 6'd0, 1'b0, WAIT_MAX - 1, WAIT_MAX - 1);
    run_instr(6'd43, 6'd0, 1'b0, WAIT_MAX - 1, WAIT_MAX - 1);
`ifndef ILLEGAL_TRAP_EN
    run_instr(6'd63, 6'd0, 1'b0, 0, 0);
`endif

    // Random instruction mix with random stall lengths.
    for (int n = 0; n < 200; n++) begin
      k  = int'($urandom_range(0, 9));
      fn = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) fn = 6'd8;
      case (k)
        0:       op = 6'd35;
        1:       op = 6'd43;
        2, 3:    op = 6'd0;
        4:       op = 6'd4;
        5:       op = 6'd5;
        6:       op = 6'd8;
        7:       op = 6'd2;
        8:       op = 6'd3;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          op = 6'd0;
`else
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
`endif
        end
      endcase
      run_instr(op, fn, rnd(), pick_wait(), pick_wait());
    end

    // Store that never completes: timeout into HALT, then reset clears mem_err.
    cur_op = 6'd43; cur_fn = 6'd0; cur_z = 1'b0;
    cyc(S_FETCH, 1'b1);
    cyc(S_DECODE, rnd());
    cyc(S_MEM_ADDR, rnd());
    for (int i = 0; i < WAIT_MAX; i++) cyc(S_MEM_WR, 1'b0);
    err_exp = 1'b1;
    for (int i = 0; i < 3; i++) cyc(S_HALT, rnd());
    do_reset();

    // Fetch that never completes.
    cur_op = 6'($urandom_range(0, 63));
    for (int i = 0; i < WAIT_MAX; i++) cyc(S_FETCH, 1'b0);
    err_exp = 1'b1;
    for (int i = 0; i < 3; i++) cyc(S_HALT, rnd());
    do_reset();

    // Reset in the middle of a load aborts it without a retire.
    cur_op = 6'd35;
    cyc(S_FETCH, 1'b1);
    cyc(S_DECODE, rnd());
    cyc(S_MEM_ADDR, rnd());
    cyc(S_MEM_RD, 1'b0);
    do_reset();

`ifdef ILLEGAL_TRAP_EN
    run_instr(6'd63, 6'd0, 1'b0, 0, 0);
    do_reset();
`endif
    run_instr(6'd35, 6'd0, 1'b0, 1, 2);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
